step3_normalize: RTL and testbench

//   Normalise/round stage of the floating MAC multiply path; consumes the 10-cycle-delayed exponent/sign

---
 rtl/step3_normalize.sv | 224 ++++++++++++++++++++++
 tb/tb_step3_normalize.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step3_normalize.sv
// -----------------------------------------------------------------------------
// step3_normalize
//
// Normalise and round stage of the floating MAC multiply path. It takes the
// biased exponent sum and the sign from step2_status, together with the 2*MW-bit
// mantissa product from the pipelined multiplier, which arrives in the same
// cycle. It then:
//   - normalises the product,
//   - rounds it to MW-1 fraction bits,
//   - saturates an overflow to infinity,
//   - flushes an underflow to signed zero,
//   - packs the result as an IEEE-754 single.
//
// The stage is a two-deep valid/ready pipeline:
//   s1  : normalised mantissa, guard/sticky, internal exponent, zero flags
//   out : rounded and packed result register that drives the outputs
//
// Configuration macro:
//   ROUND_NEAREST_EN  defined   -> round to nearest, ties to even
//                     undefined -> truncation; guard/sticky are not kept and
//                                  there is no rounding-carry path
//
// Ports:
//   clock          in   1      rising-edge clock
//   resetn         in   1      asynchronous active-low reset
//   in_valid       in   1      input beat valid
//   in_ready       out  1      stage can accept a beat this cycle
//   in_ex_add_out  in   EW     biased exponent sum; 0 means underflowed/zero
//   in_out_sign    in   1      result sign
//   in_mant_prod   in   2*MW   unsigned product in [1,4) or 0
//   out_valid      out  1      output beat valid
//   out_ready      in   1      downstream accepts the beat
//   out_result     out  32     packed {sign, exp, frac}
//   out_ovf        out  1      result saturated to infinity
//   out_unf        out  1      nonzero result flushed to signed zero
// -----------------------------------------------------------------------------
module step3_normalize #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [EW-1:0]   in_ex_add_out,
  input  logic            in_out_sign,
  input  logic [2*MW-1:0] in_mant_prod,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_result,
  output logic            out_ovf,
  output logic            out_unf
);

  localparam int PW = 2 * MW;  // product width
  localparam int XW = EW + 1;  // internal exponent width, with headroom for the carries
  localparam logic [XW-1:0] EXP_INF = XW'((1 << EW) - 1);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic out_load;
  logic s1_load;

  // The output register is free when it is empty or is being drained this cycle.
  // Stage 1 can then always move forward, so both stages shift together when
  // the pipe is full, the downstream takes a beat and a new beat arrives.
  assign out_load = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || out_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
    end
    if (out_load) begin
      out_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: normalise
  // ---------------------------------------------------------------------------
  logic          prod_hi;
  logic          s1_sign_d, s1_sign_q;
  logic [XW-1:0] s1_exp_d,  s1_exp_q;
  logic [MW-1:0] s1_mant_d, s1_mant_q;
  logic          s1_zero_d, s1_zero_q;
  logic          s1_unf_d,  s1_unf_q;
`ifdef ROUND_NEAREST_EN
  logic          s1_guard_d,  s1_guard_q;
  logic          s1_sticky_d, s1_sticky_q;
`endif

  // When the product is in [2,4) the top bit is set. The binary point then
  // moves one place and the exponent gains one.
  assign prod_hi = in_mant_prod[PW-1];

  always_comb begin
    s1_sign_d = in_out_sign;
    s1_exp_d  = {1'b0, in_ex_add_out};
    s1_mant_d = in_mant_prod[PW-2 -: MW];
`ifdef ROUND_NEAREST_EN
    s1_guard_d  = in_mant_prod[PW-MW-2];
    s1_sticky_d = |in_mant_prod[PW-MW-3:0];
`endif
    if (prod_hi) begin
      s1_exp_d  = {1'b0, in_ex_add_out} + XW'(1);
      s1_mant_d = in_mant_prod[PW-1 -: MW];
`ifdef ROUND_NEAREST_EN
      s1_guard_d  = in_mant_prod[PW-MW-1];
      s1_sticky_d = |in_mant_prod[PW-MW-2:0];
`endif
    end
    // A zero exponent sum means the exponent already underflowed upstream.
    // A zero product is an exact zero and is not reported as an underflow.
    s1_zero_d = (in_mant_prod == '0) || (in_ex_add_out == '0);
    s1_unf_d  = s1_zero_d && (in_mant_prod != '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_mant_q <= '0;
      s1_zero_q <= 1'b0;
      s1_unf_q  <= 1'b0;
`ifdef ROUND_NEAREST_EN
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
`endif
    end else if (s1_load && in_valid) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_mant_q <= s1_mant_d;
      s1_zero_q <= s1_zero_d;
      s1_unf_q  <= s1_unf_d;
`ifdef ROUND_NEAREST_EN
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round and pack
  // ---------------------------------------------------------------------------
  logic [MW-1:0]    rnd_mant;
  logic [XW-1:0]    rnd_exp;
  logic             res_ovf;
  logic [EW+MW-1:0] res_word;
  logic [EW+MW-1:0] out_result_q;
  logic             out_ovf_q;
  logic             out_unf_q;

`ifdef ROUND_NEAREST_EN
  logic          rnd_inc;
  logic [MW:0]   rnd_sum;

  // Round to nearest, ties to even. A carry out of the mantissa leaves it at
  // exactly 2.0, which renormalises to 1.0 with the exponent one higher.
  always_comb begin
    rnd_inc  = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
    rnd_sum  = {1'b0, s1_mant_q} + {{MW{1'b0}}, rnd_inc};
    rnd_mant = rnd_sum[MW-1:0];
    rnd_exp  = s1_exp_q;
    if (rnd_sum[MW]) begin
      rnd_mant = {1'b1, {(MW-1){1'b0}}};
      rnd_exp  = s1_exp_q + XW'(1);
    end
  end
`else
  always_comb begin
    rnd_mant = s1_mant_q;
    rnd_exp  = s1_exp_q;
  end
`endif

  // Overflow takes priority over the zero flag. Both can only be true together
  // for an infinite exponent input, and upstream never produces one.
  always_comb begin
    res_ovf  = (rnd_exp >= EXP_INF);
    res_word = {s1_sign_q, rnd_exp[EW-1:0], rnd_mant[MW-2:0]};
    if (res_ovf) begin
      res_word = {s1_sign_q, {EW{1'b1}}, {(MW-1){1'b0}}};
    end else if (s1_zero_q) begin
      res_word = {s1_sign_q, {(EW+MW-1){1'b0}}};
    end
  end

  // The result register loads only when a real beat moves in. A stalled beat
  // therefore stays bit-stable, and a bubble does not disturb the last value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
      out_unf_q    <= 1'b0;
    end else if (out_load && s1_valid_q) begin
      out_result_q <= res_word;
      out_ovf_q    <= res_ovf;
      out_unf_q    <= !res_ovf && s1_unf_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;
  assign out_unf    = out_unf_q;

endmodule

// File: tb/tb_step3_normalize.sv
module tb_step3_normalize;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ex_add_out;
  logic        in_out_sign;
  logic [47:0] in_mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  step3_normalize dut (
    .clock         (clock),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ex_add_out (in_ex_add_out),
    .in_out_sign   (in_out_sign),
    .in_mant_prod  (in_mant_prod),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_ovf       (out_ovf),
    .out_unf       (out_unf)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] sb[$];      // expected {ovf, unf, result}
  bit          rand_ready = 1'b0;

  // Reference: treat the product as an integer scaled by 2^46 and work out the
  // result arithmetically.
  function automatic logic [33:0] ref_model(logic [7:0] ex, logic sign, logic [47:0] prod);
    longint unsigned p, m, rem, half;
    int sh, e;
    logic [31:0] res;
    if (prod == 48'd0 || ex == 8'd0)
      return {1'b0, (prod != 48'd0), sign, 31'd0};
    p    = 64'(prod);
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    e    = int'(ex) + ((sh == 24) ? 1 : 0);
`ifdef ROUND_NEAREST_EN
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
`else
    if (rem > half) m = m;
`endif
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {1'b1, 1'b0, sign, 8'hFF, 23'd0};
    res = {sign, e[7:0], m[22:0]};
    return {2'b00, res};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [33:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat", {out_ovf, out_unf, out_result});
        end else begin
          e = sb.pop_front();
          check("out_beat", 64'({out_ovf, out_unf, out_result}), 64'(e));
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic drive_beat(logic [7:0] ex, logic sign, logic [47:0] prod, logic [33:0] exp);
    int waited = 0;
    in_valid      = 1'b1;
    in_ex_add_out = ex;
    in_out_sign   = sign;
    in_mant_prod  = prod;
    #1;
    while (!in_ready) begin
      if (waited >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", waited);
        in_valid = 1'b0;
        return;
      end
      next_cycle();
      #1;
      waited++;
    end
    sb.push_back(exp);
    next_cycle();
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) next_cycle();
    repeat (2) next_cycle();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] held;
  int          seen;
  logic [63:0] r;
  logic [47:0] p;
  logic [23:0] ma, mb;
  logic [7:0]  ex;
  logic        sg;
  int          kind;

  initial begin
    resetn        = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    in_ex_add_out = '0;
    in_out_sign   = 1'b0;
    in_mant_prod  = '0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_word", 64'({out_ovf, out_unf, out_result}), 64'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    fork
      monitor();
    join_none

    // Directed cases, with the first one also used to check the latency.
    out_ready = 1'b1;
    drive_beat(8'd127, 1'b0, 48'h4000_0000_0000, {2'b00, 32'h3F80_0000});
    in_valid = 1'b0;
    #1;
    check("lat_cycle1", 64'(out_valid), 64'd0);
    next_cycle();
    #1;
    check("lat_cycle2", 64'(out_valid), 64'd1);
    drive_beat(8'd127, 1'b1, 48'h9000_0000_0000, {2'b00, 32'hC010_0000});
`ifdef ROUND_NEAREST_EN
    drive_beat(8'd127, 1'b0, 48'h4000_00C0_0000, {2'b00, 32'h3F80_0002});
    drive_beat(8'd127, 1'b0, 48'hFFFF_FF80_0000, {2'b00, 32'h4080_0000});
    drive_beat(8'd253, 1'b0, 48'hFFFF_FF80_0000, {2'b10, 32'h7F80_0000});
`else
    drive_beat(8'd127, 1'b0, 48'h4000_00C0_0000, {2'b00, 32'h3F80_0001});
    drive_beat(8'd127, 1'b0, 48'hFFFF_FF80_0000, {2'b00, 32'h407F_FFFF});
    drive_beat(8'd253, 1'b0, 48'hFFFF_FF80_0000, {2'b00, 32'h7F7F_FFFF});
`endif
    drive_beat(8'd254, 1'b0, 48'h9000_0000_0000, {2'b10, 32'h7F80_0000});
    drive_beat(8'd0,   1'b0, 48'h4000_0000_0000, {2'b01, 32'h0000_0000});
    drive_beat(8'd127, 1'b1, 48'h0,              {2'b00, 32'h8000_0000});
    drive_beat(8'd1,   1'b0, 48'h4000_0000_0000, {2'b00, 32'h0080_0000});
    drive_beat(8'd253, 1'b1, 48'h9000_0000_0000, {2'b00, 32'hFF10_0000});
    drain();

    // Back-pressure: three beats back to back while the downstream stalls.
    out_ready = 1'b0;
    drive_beat(8'd100, 1'b0, 48'h4000_0000_0000, ref_model(8'd100, 1'b0, 48'h4000_0000_0000));
    drive_beat(8'd101, 1'b1, 48'h9000_0000_0000, ref_model(8'd101, 1'b1, 48'h9000_0000_0000));
    in_ex_add_out = 8'd102;
    in_out_sign   = 1'b0;
    in_mant_prod  = 48'h6000_0000_0000;
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    held = out_result;
    check("stall_first_word", 64'(held), 64'(ref_model(8'd100, 1'b0, 48'h4000_0000_0000)));
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      check("stall_hold_ready", 64'(in_ready), 64'd0);
      check("stall_hold_word", 64'(out_result), 64'(held));
    end
    out_ready = 1'b1;
    drive_beat(8'd102, 1'b0, 48'h6000_0000_0000, ref_model(8'd102, 1'b0, 48'h6000_0000_0000));
    drain();

    // Reset while two beats are in flight.
    out_ready = 1'b0;
    drive_beat(8'd120, 1'b1, 48'h5000_0000_0000, ref_model(8'd120, 1'b1, 48'h5000_0000_0000));
    drive_beat(8'd121, 1'b0, 48'h7000_0000_0000, ref_model(8'd121, 1'b0, 48'h7000_0000_0000));
    in_valid = 1'b0;
    next_cycle();
    #1;
    check("inflight_valid", 64'(out_valid), 64'd1);
    resetn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_word", 64'({out_ovf, out_unf, out_result}), 64'd0);
    sb.delete();
    next_cycle();
    next_cycle();
    resetn    = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      #1;
      if (out_valid) seen++;
    end
    check("post_rst_no_beat", 64'(seen), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Randomised traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r    = {$urandom, $urandom};
      p    = r[47:0];
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: p = 48'd0;
        1: begin p[47] = 1'b1; p[23:0] = 24'h80_0000; end
        2: begin p[47] = 1'b0; p[46] = 1'b1; p[22:0] = 23'h40_0000; end
        3: begin p[47:23] = '1; end
        4, 5: begin
          ma = {1'b1, r[22:0]};
          mb = {1'b1, r[54:32]};
          p  = 48'(ma) * 48'(mb);
        end
        default: if (!p[47]) p[46] = 1'b1;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: ex = 8'd0;
          1: ex = 8'd1;
          2: ex = 8'd253;
          default: ex = 8'd254;
        endcase
      end else begin
        ex = 8'($urandom_range(0, 254));
      end
      sg = r[63];
      drive_beat(ex, sg, p, ref_model(ex, sg, p));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
